add_nibble_seq: RTL and testbench



---
 rtl/add_nibble_seq.sv | 121 ++++++++++++
 tb/tb_add_nibble_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_nibble_seq.sv
// Multi-precision add sequencer: feeds an external 4-bit adder one nibble
// per clock (LSB first), chains its carry and assembles the WIDTH-bit sum.
module add_nibble_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [3:0]       add_r1,
   output logic [3:0]       add_r2,
   output logic             add_ci,
   input  logic [3:0]       add_result,
   input  logic             add_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IW'(i)) begin
                  sum_d[4*i +: 4] = add_result;
               end
            end
            carry_d = add_carry;
            if (idx_q == LAST) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Adder operands are only driven while a nibble is in flight.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == RUN) || (state_q == DONE);
      add_r1    = 4'd0;
      add_r2    = 4'd0;
      add_ci    = 1'b0;
      if (state_q == RUN) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
               add_r1 = a_q[4*i +: 4];
               add_r2 = b_q[4*i +: 4];
            end
         end
         add_ci = carry_q;
      end
   end

   assign sum  = sum_q;
   assign cout = carry_q;

endmodule

// File: tb/tb_add_nibble_seq.sv
// Bench for add_nibble_seq: WIDTH=16 and WIDTH=4 instances, each wired to
// a behavioural 4-bit adder; table vectors, random ops and corner sequences.
module tb_add_nibble_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // WIDTH=16 instance
   logic        iv16, ir16, ov16, or16, ci16, co16, busy16;
   logic [15:0] a16, b16, s16;
   logic [3:0]  r1_16, r2_16, res16;
   logic        aci16, acar16;

   assign {acar16, res16} = {1'b0, r1_16} + {1'b0, r2_16} + {4'd0, aci16};

   add_nibble_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .cin(ci16),
      .add_r1(r1_16), .add_r2(r2_16), .add_ci(aci16),
      .add_result(res16), .add_carry(acar16),
      .out_valid(ov16), .out_ready(or16),
      .sum(s16), .cout(co16), .busy(busy16)
   );

   // WIDTH=4 instance
   logic       iv4, ir4, ov4, or4, ci4, co4, busy4;
   logic [3:0] a4, b4, s4, r1_4, r2_4, res4;
   logic       aci4, acar4;

   assign {acar4, res4} = {1'b0, r1_4} + {1'b0, r2_4} + {4'd0, aci4};

   add_nibble_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .cin(ci4),
      .add_r1(r1_4), .add_r2(r2_4), .add_ci(aci4),
      .add_result(res4), .add_carry(acar4),
      .out_valid(ov4), .out_ready(or4),
      .sum(s4), .cout(co4), .busy(busy4)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        co;
   } vec_t;

   vec_t        vt[6];
   logic [16:0] sbq[$];
   logic [3:0]  tr_r1[8];
   logic [3:0]  tr_r2[8];
   logic        tr_ci[8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one 16-bit op, trace RUN cycles, optionally stall DONE, drain.
   task automatic op16(input logic [15:0] ai, input logic [15:0] bi,
                       input logic ci, input logic [16:0] exp,
                       input int hold);
      int n;
      int lat;
      logic [16:0] e;
      n = 0;
      while (!ir16 && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_wait", 32'(ir16), 32'd1);
      a16  = ai;
      b16  = bi;
      ci16 = ci;
      iv16 = 1'b1;
      or16 = 1'b0;
      tick();
      iv16 = 1'b0;
      sbq.push_back(exp);
      lat = 0;
      while (!ov16 && lat < 8) begin
         tr_r1[lat] = r1_16;
         tr_r2[lat] = r2_16;
         tr_ci[lat] = aci16;
         chk("busy_run", 32'(busy16), 32'd1);
         tick();
         lat++;
      end
      chk("latency16", 32'(lat), 32'd4);
      e = sbq.pop_front();
      for (int h = 0; h < hold; h++) begin
         iv16 = 1'b1;
         a16  = 16'hAAAA;
         b16  = 16'h5555;
         chk("hold_sum", 32'(s16), 32'(e[15:0]));
         chk("hold_cout", 32'(co16), 32'(e[16]));
         chk("hold_in_ready", 32'(ir16), 32'd0);
         chk("hold_valid", 32'(ov16), 32'd1);
         tick();
      end
      iv16 = 1'b0;
      chk("sum16", 32'(s16), 32'(e[15:0]));
      chk("cout16", 32'(co16), 32'(e[16]));
      chk("done_r1_zero", 32'({r1_16, r2_16, aci16}), 32'd0);
      or16 = 1'b1;
      tick();
      or16 = 1'b0;
      chk("idle_in_ready", 32'(ir16), 32'd1);
      chk("idle_valid", 32'(ov16), 32'd0);
      chk("idle_busy", 32'(busy16), 32'd0);
      chk("idle_sum_kept", 32'(s16), 32'(e[15:0]));
   endtask

   initial begin
      int lat;
      logic [15:0] ra, rb;
      logic        rc;
      vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vt[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vt[5] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};

      rst_n = 1'b0;
      {iv16, or16, ci16, a16, b16} = '0;
      {iv4, or4, ci4, a4, b4} = '0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(ir16), 32'd1);
      chk("rst_out_valid", 32'(ov16), 32'd0);
      chk("rst_busy", 32'(busy16), 32'd0);
      chk("rst_sum", 32'(s16), 32'd0);
      chk("rst_cout", 32'(co16), 32'd0);
      chk("rst_adder", 32'({r1_16, r2_16, aci16}), 32'd0);

      for (int i = 0; i < 6; i++) begin
         op16(vt[i].a, vt[i].b, vt[i].cin, {vt[i].co, vt[i].s}, 0);
         if (i == 0) begin
            chk("run3_r1", 32'(tr_r1[2]), 32'h2);
            chk("run3_r2", 32'(tr_r2[2]), 32'h3);
            chk("run3_ci", 32'(tr_ci[2]), 32'd0);
         end
         if (i == 1) begin
            chk("ripple_ci0", 32'(tr_ci[0]), 32'd0);
            chk("ripple_ci1", 32'(tr_ci[1]), 32'd1);
            chk("ripple_ci2", 32'(tr_ci[2]), 32'd1);
            chk("ripple_ci3", 32'(tr_ci[3]), 32'd1);
         end
      end

      // Backpressure with a competing request that must be ignored.
      op16(16'h1234, 16'h4321, 1'b0, 17'h05555, 3);

      // Reset two RUN edges into an operation.
      a16  = 16'h1234;
      b16  = 16'h4321;
      ci16 = 1'b0;
      iv16 = 1'b1;
      tick();
      iv16 = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_valid", 32'(ov16), 32'd0);
      chk("midrst_sum", 32'(s16), 32'd0);
      chk("midrst_busy", 32'(busy16), 32'd0);
      chk("midrst_in_ready", 32'(ir16), 32'd1);
      chk("midrst_adder", 32'({r1_16, r2_16, aci16}), 32'd0);
      op16(16'h1234, 16'h4321, 1'b0, 17'h05555, 0);

      for (int k = 0; k < 8; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         op16(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'd0, rc}, k % 2);
      end

      // WIDTH=4 single-nibble operation.
      a4  = 4'h9;
      b4  = 4'h8;
      ci4 = 1'b1;
      iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      lat = 0;
      while (!ov4 && lat < 8) begin
         tick();
         lat++;
      end
      chk("latency4", 32'(lat), 32'd1);
      chk("sum4", 32'(s4), 32'h2);
      chk("cout4", 32'(co4), 32'd1);
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
      chk("idle4_in_ready", 32'(ir4), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
